// File: rtl/spinvaders_renderer_if.sv
// Pixel-path bundle between the VGA timing / game-state sources and the
// Space Invaders renderer: timing counters and game state in, RGB and frame tick out.
interface spinvaders_renderer_if;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        bright;
    logic [6:0]  topRow;
    logic [6:0]  midRow;
    logic [6:0]  botRow;
    logic [9:0]  topY;
    logic [9:0]  midY;
    logic [9:0]  botY;
    logic [9:0]  xInvader;
    logic [9:0]  shipX;
    logic [9:0]  projX;
    logic [9:0]  projY;
    logic [11:0] rgb;
    logic        frame_tick;

    modport master (
        output hCount, vCount, bright,
        output topRow, midRow, botRow, topY, midY, botY,
        output xInvader, shipX, projX, projY,
        input  rgb, frame_tick
    );

    modport slave (
        input  hCount, vCount, bright,
        input  topRow, midRow, botRow, topY, midY, botY,
        input  xInvader, shipX, projX, projY,
        output rgb, frame_tick
    );
endinterface

// File: rtl/spinvaders_renderer.sv
// Space Invaders pixel generator: per-frame game-state snapshot, parallel hit
// tests (stage 1) and priority colour mux (stage 2). Optional macro: SPINV_ANIM_EN.
module spinvaders_renderer #(
    parameter int ALIEN_PITCH  = 100,
    parameter int ALIEN_HALF_W = 10,
    parameter int ALIEN_HALF_H = 10,
    parameter int SHIP_Y       = 400,
    parameter int SHIP_HALF_W  = 15,
    parameter int SHIP_HALF_H  = 5,
    parameter int PROJ_HALF_W  = 1,
    parameter int PROJ_HALF_H  = 4,
    parameter int PROJ_NONE    = 900
) (
    input  logic                  Clk,
    input  logic                  reset,
    spinvaders_renderer_if.slave  bus
);
    localparam int NUM_COLS = 7;
    localparam int NUM_ROWS = 3;

    localparam logic [10:0] A_HW      = 11'(ALIEN_HALF_W);
    localparam logic [10:0] A_HH      = 11'(ALIEN_HALF_H);
    localparam logic [10:0] S_HW      = 11'(SHIP_HALF_W);
    localparam logic [10:0] S_HH      = 11'(SHIP_HALF_H);
    localparam logic [10:0] P_HW      = 11'(PROJ_HALF_W);
    localparam logic [10:0] P_HH      = 11'(PROJ_HALF_H);
    localparam logic [10:0] S_Y       = 11'(SHIP_Y);
    localparam logic [9:0]  P_NONE    = 10'(PROJ_NONE);
    localparam logic [9:0]  SHIP_X_RST = 10'd400;

    // Inclusive window test without subtraction so nothing wraps near 0 or 1023.
    function automatic logic in_span(input logic [10:0] pix,
                                     input logic [10:0] centre,
                                     input logic [10:0] half);
        return ((pix + half) >= centre) && (pix <= (centre + half));
    endfunction

    logic snap;
    assign snap = (bus.hCount == 10'd0) && (bus.vCount == 10'd480);

    // ---------------- per-frame shadow of the game state ----------------
    logic [6:0] mask_reg  [NUM_ROWS];
    logic [9:0] row_y_reg [NUM_ROWS];
    logic [9:0] x_inv_reg;
    logic [9:0] ship_x_reg;
    logic [9:0] proj_x_reg;
    logic [9:0] proj_y_reg;
    logic       frame_tick_reg;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            mask_reg[0]    <= '0;
            mask_reg[1]    <= '0;
            mask_reg[2]    <= '0;
            row_y_reg[0]   <= '0;
            row_y_reg[1]   <= '0;
            row_y_reg[2]   <= '0;
            x_inv_reg      <= '0;
            ship_x_reg     <= SHIP_X_RST;
            proj_x_reg     <= P_NONE;
            proj_y_reg     <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            frame_tick_reg <= snap;
            if (snap) begin
                mask_reg[0]  <= bus.topRow;
                mask_reg[1]  <= bus.midRow;
                mask_reg[2]  <= bus.botRow;
                row_y_reg[0] <= bus.topY;
                row_y_reg[1] <= bus.midY;
                row_y_reg[2] <= bus.botY;
                x_inv_reg    <= bus.xInvader;
                ship_x_reg   <= bus.shipX;
                proj_x_reg   <= bus.projX;
                proj_y_reg   <= bus.projY;
            end
        end
    end

    // ---------------- optional colour animation ----------------
    logic alien_alt;
`ifdef SPINV_ANIM_EN
    logic [5:0] anim_cnt_reg;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            anim_cnt_reg <= '0;
        end else if (snap) begin
            anim_cnt_reg <= anim_cnt_reg + 6'd1;
        end
    end

    assign alien_alt = anim_cnt_reg[5];
`else
    assign alien_alt = 1'b0;
`endif

    // ---------------- stage 1: parallel hit tests ----------------
    logic [10:0] pix_h;
    logic [10:0] pix_v;
    assign pix_h = {1'b0, bus.hCount};
    assign pix_v = {1'b0, bus.vCount};

    logic [10:0]         col_x [NUM_COLS];
    logic [NUM_COLS-1:0] col_h_hit;
    logic [NUM_ROWS-1:0] row_v_hit;
    logic [NUM_ROWS-1:0] row_hit;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
            assign col_x[gi] = {1'b0, x_inv_reg} + 11'(gi * ALIEN_PITCH);
            // A centre at or beyond 1024 is off-screen and must never alias back.
            assign col_h_hit[gi] = !col_x[gi][10] && in_span(pix_h, col_x[gi], A_HW);
        end
        for (gj = 0; gj < NUM_ROWS; gj++) begin : g_row
            assign row_v_hit[gj] = in_span(pix_v, {1'b0, row_y_reg[gj]}, A_HH);
            assign row_hit[gj]   = row_v_hit[gj] && |(mask_reg[gj] & col_h_hit);
        end
    endgenerate

    logic ship_hit;
    logic proj_hit;
    assign ship_hit = in_span(pix_h, {1'b0, ship_x_reg}, S_HW) &&
                      in_span(pix_v, S_Y, S_HH);
    assign proj_hit = (proj_x_reg != P_NONE) &&
                      in_span(pix_h, {1'b0, proj_x_reg}, P_HW) &&
                      in_span(pix_v, {1'b0, proj_y_reg}, P_HH);

    logic                bright_reg;
    logic                proj_hit_reg;
    logic                ship_hit_reg;
    logic [NUM_ROWS-1:0] row_hit_reg;
    logic                alt_reg;

    // The animation bit rides with the pixel so a snapshot-cycle pixel keeps old colours.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            bright_reg   <= 1'b0;
            proj_hit_reg <= 1'b0;
            ship_hit_reg <= 1'b0;
            row_hit_reg  <= '0;
            alt_reg      <= 1'b0;
        end else begin
            bright_reg   <= bus.bright;
            proj_hit_reg <= proj_hit;
            ship_hit_reg <= ship_hit;
            row_hit_reg  <= row_hit;
            alt_reg      <= alien_alt;
        end
    end

    // ---------------- stage 2: priority colour mux ----------------
    logic [11:0] rgb_next;
    logic [11:0] rgb_reg;

    always_comb begin
        rgb_next = 12'h000;
        if (bright_reg) begin
            if (proj_hit_reg)        rgb_next = 12'hFFF;
            else if (ship_hit_reg)   rgb_next = 12'h0F0;
            else if (row_hit_reg[0]) rgb_next = alt_reg ? 12'hF80 : 12'hF0F;
            else if (row_hit_reg[1]) rgb_next = alt_reg ? 12'hF80 : 12'h0FF;
            else if (row_hit_reg[2]) rgb_next = alt_reg ? 12'hF80 : 12'hFF0;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rgb_reg <= 12'h000;
        end else begin
            rgb_reg <= rgb_next;
        end
    end

    assign bus.rgb        = rgb_reg;
    assign bus.frame_tick = frame_tick_reg;
endmodule

// File: doc/spinvaders_renderer.md
# spinvaders_renderer

Pixel generator for the Space Invaders display path. It consumes the game-state outputs of the invader state machine: row alive masks, row Y positions, invader X origin, ship position and projectile position. It also takes the VGA timing counters and produces one registered 12-bit RGB value per pixel clock. Game state is snapshotted once per frame so a frame never tears mid-scan.

## Interface
Parameters:
- ALIEN_PITCH, 100, horizontal distance between alien column centres (px)
- ALIEN_HALF_W, 10, alien half-width (px)
- ALIEN_HALF_H, 10, alien half-height (px)
- SHIP_Y, 400, ship centre row (px)
- SHIP_HALF_W, 15, ship half-width; SHIP_HALF_H, 5, ship half-height
- PROJ_HALF_W, 1, projectile half-width; PROJ_HALF_H, 4, projectile half-height
- PROJ_NONE, 900, projectile X value meaning "no projectile"

Ports:
- Clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- hCount  in  10  current pixel column
- vCount  in  10  current pixel row
- bright  in  1  visible-area enable, aligned with hCount/vCount
- topRow, midRow, botRow  in  7 each  alive mask, bit i = alien column i
- topY, midY, botY  in  10 each  row centre Y
- xInvader  in  10  centre X of column 0
- shipX  in  10  ship centre X
- projX, projY  in  10 each  projectile centre; projX==PROJ_NONE means absent
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}, registered
- frame_tick  out  1  one-cycle pulse when the snapshot is taken

## Operation
- Snapshot: on the cycle where hCount==0 and vCount==480, all game-state inputs load into shadow registers and frame_tick=1. All drawing uses shadow values only.
- Hit tests in pipeline stage 1, all in parallel:
  - Alien (r,i): alive bit set and |hCount − (xInvader + i·ALIEN_PITCH)| ≤ ALIEN_HALF_W and |vCount − rowY| ≤ ALIEN_HALF_H. Seven columns × three rows are compared in parallel; there is no divider.
  - Ship: |hCount−shipX| ≤ SHIP_HALF_W and |vCount−SHIP_Y| ≤ SHIP_HALF_H.
  - Projectile: projX≠PROJ_NONE and within PROJ_HALF_W/PROJ_HALF_H of (projX, projY).
- Arithmetic: each test is "pix + HALF ≥ centre and pix ≤ centre + HALF", evaluated at 11 bits zero-extended. No subtraction is used, so centres near 0 or 1023 never wrap. Column centres that overflow 10 bits (xInvader + i·PITCH ≥ 1024) are never drawn.
- Stage 2 priority mux, registered into rgb:
  - bright=0 → 12'h000
  - projectile → 12'hFFF
  - ship → 12'h0F0
  - top row → 12'hF0F
  - mid row → 12'h0FF
  - bot row → 12'hFF0
  - otherwise 12'h000
- Overlapping alien rows resolve top > mid > bot.

## Timing
- Latency: hCount/vCount/bright to rgb is exactly 2 cycles. bright is pipelined alongside the tests.
- Input changes outside the snapshot cycle do not affect the current frame.
- Reset values:
  - rgb=0, frame_tick=0
  - shadow masks=0, so no aliens are drawn
  - shadow projX=PROJ_NONE; shadow shipX=400; shadow Y values=0
  - pipeline registers cleared
- Reset asserted mid-frame: rgb forced to 0 immediately (asynchronous). After release, only the ship is drawn, at X 400, until the next snapshot.
- Snapshot cycle with bright=1 is impossible under 640×480 timing. If it occurs anyway, the snapshot still occurs and pixel output is unaffected.

## Configuration
- SPINV_ANIM_EN defined: an internal 6-bit frame counter increments on each frame_tick (wraps 63→0). When counter bit 5 is 1, all three alien row colours are replaced by 12'hF80; otherwise the normal row colours apply. Reset clears the counter.
- SPINV_ANIM_EN undefined: no counter is built and alien colours are fixed. Everything else is identical.

## Test plan
- Reset release, then scan a full frame with defaults → rgb=12'h0F0 only for h∈[385,415], v∈[395,405]; frame_tick pulses once at (h=0, v=480).
- Present topRow=7'b0000001, topY=30, xInvader=30, then snapshot → pixel (30,30) gives rgb=12'hF0F two cycles after it is presented; (41,30) and (30,41) give 0.
- projX=200, projY=400, shipX=200 → (200,400) gives 12'hFFF (projectile beats ship); (210,400) gives 12'h0F0.
- xInvader=5, midRow=7'h7F, midY=90 → (0,90) is alien colour 12'h0FF (no wrap). Column 6 centre = 605; (615,90) drawn, (616,90) not drawn.
- Change topRow mid-frame at v=200 → rows below 200 unchanged this frame; the change appears only after the next frame_tick.
- SPINV_ANIM_EN defined: after 32 frame_ticks the alien pixel at (30,30) reads 12'hF80; after 64 it reads 12'hF0F again. Reset at any point returns it to 12'hF0F on the next frame.
